// File: rtl/hwregs_arbiter_if.sv
`default_nettype none
// hwregs_arbiter_if: one bus-master port of the hwregs arbiter (request channel plus read response).
// Rev 1.0
interface hwregs_arbiter_if;
   logic        request;
   logic        ready;
   logic        write;
   logic [15:0] address;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic        rvalid;
   logic [8:0]  rtag;
   logic [31:0] rdata;

   modport master (
      output request, write, address, wmask, wdata,
      input  ready, rvalid, rtag, rdata
   );

   modport slave (
      input  request, write, address, wmask, wdata,
      output ready, rvalid, rtag, rdata
   );
endinterface
`default_nettype wire

// File: rtl/hwregs_arbiter.sv
`default_nettype none
// hwregs_arbiter: shares the hwregs register bus between two masters with one-entry slots,
// round-robin or m0-priority arbitration, and latency-matched read-response routing. Rev 1.0
module hwregs_arbiter #(
   parameter int RESP_LATENCY = 1,
   parameter int M0_PRIORITY  = 0
) (
   input  logic            clock,
   input  logic            reset_n,
   hwregs_arbiter_if.slave m0,
   hwregs_arbiter_if.slave m1,
   output logic            hwregs_request,
   output logic            hwregs_write,
   output logic [15:0]     hwregs_address,
   output logic [3:0]      hwregs_wmask,
   output logic [31:0]     hwregs_wdata,
   input  logic            hwregs_rvalid,
   input  logic [8:0]      hwregs_rtag,
   input  logic [31:0]     hwregs_rdata,
   output logic            resp_error
);

   localparam int SLOT_W = 1 + 16 + 4 + 32;

   logic [1:0]              req;
   logic [SLOT_W-1:0]       in_word [2];
   logic [1:0]              full;
   logic [SLOT_W-1:0]       slot [2];
   logic                    rr_next;
   logic                    issued_owner;
   logic                    any_full;
   logic                    winner;
   logic [1:0]              issuing;
   logic [1:0]              ready;
   logic [RESP_LATENCY-1:0] pipe_valid;
   logic [RESP_LATENCY-1:0] pipe_owner;
   logic                    out_valid;
   logic                    out_owner;

   assign req        = {m1.request, m0.request};
   assign in_word[0] = {m0.write, m0.address, m0.wmask, m0.wdata};
   assign in_word[1] = {m1.write, m1.address, m1.wmask, m1.wdata};

   always_comb begin
      any_full = |full;
      winner   = 1'b0;
      if (full == 2'b10)
         winner = 1'b1;
      else if (full == 2'b11)
         winner = (M0_PRIORITY != 0) ? 1'b0 : rr_next;
      issuing = 2'b00;
      if (any_full)
         issuing = winner ? 2'b10 : 2'b01;
      // A slot being issued this edge can take a new entry on the same edge.
      ready = ~full | issuing;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         full <= 2'b00;
         for (int i = 0; i < 2; i++)
            slot[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (req[i] && ready[i]) begin
               full[i] <= 1'b1;
               slot[i] <= in_word[i];
            end else if (issuing[i]) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hwregs_request <= 1'b0;
         hwregs_write   <= 1'b0;
         hwregs_address <= '0;
         hwregs_wmask   <= '0;
         hwregs_wdata   <= '0;
         issued_owner   <= 1'b0;
         rr_next        <= 1'b0;
      end else begin
         hwregs_request <= any_full;
         if (any_full) begin
            {hwregs_write, hwregs_address, hwregs_wmask, hwregs_wdata} <= slot[winner];
            issued_owner <= winner;
            rr_next      <= ~winner;
         end
      end
   end

   // Stage 0 fills the cycle after the request, so the last stage lines up with rvalid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pipe_valid <= '0;
         pipe_owner <= '0;
      end else begin
         for (int i = RESP_LATENCY - 1; i > 0; i--) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_owner[i] <= pipe_owner[i-1];
         end
         pipe_valid[0] <= hwregs_request && !hwregs_write;
         pipe_owner[0] <= issued_owner;
      end
   end

   assign out_valid = pipe_valid[RESP_LATENCY-1];
   assign out_owner = pipe_owner[RESP_LATENCY-1];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         resp_error <= 1'b0;
      else if (hwregs_rvalid && !out_valid)
         resp_error <= 1'b1;
   end

   assign m0.ready  = ready[0];
   assign m1.ready  = ready[1];
   assign m0.rvalid = hwregs_rvalid && out_valid && !out_owner;
   assign m1.rvalid = hwregs_rvalid && out_valid && out_owner;
   assign m0.rtag   = hwregs_rtag;
   assign m1.rtag   = hwregs_rtag;
   assign m0.rdata  = hwregs_rdata;
   assign m1.rdata  = hwregs_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hwregs_arbiter.sv
`default_nettype none
// tb_hwregs_arbiter: directed bench driving three arbiter variants (round-robin, m0 priority,
// three-cycle response latency) from one shared stimulus stream. Rev 1.0
module tb_hwregs_arbiter;

   logic        clock;
   logic        rst_n;
   logic [53:0] m0_bus;
   logic [53:0] m1_bus;
   logic        hw_rvalid;
   logic [8:0]  hw_rtag;
   logic [31:0] hw_rdata;
   int          n_tests;
   int          n_fail;

   logic        rr_req, rr_wr, rr_err;
   logic [15:0] rr_addr;
   logic [3:0]  rr_mask;
   logic [31:0] rr_wdata;
   logic        pr_req, pr_wr, pr_err;
   logic [15:0] pr_addr;
   logic [3:0]  pr_mask;
   logic [31:0] pr_wdata;
   logic        lt_req, lt_wr, lt_err;
   logic [15:0] lt_addr;
   logic [3:0]  lt_mask;
   logic [31:0] lt_wdata;

   hwregs_arbiter_if a0 ();
   hwregs_arbiter_if a1 ();
   hwregs_arbiter_if p0 ();
   hwregs_arbiter_if p1 ();
   hwregs_arbiter_if l0 ();
   hwregs_arbiter_if l1 ();

   assign {a0.request, a0.write, a0.address, a0.wmask, a0.wdata} = m0_bus;
   assign {a1.request, a1.write, a1.address, a1.wmask, a1.wdata} = m1_bus;
   assign {p0.request, p0.write, p0.address, p0.wmask, p0.wdata} = m0_bus;
   assign {p1.request, p1.write, p1.address, p1.wmask, p1.wdata} = m1_bus;
   assign {l0.request, l0.write, l0.address, l0.wmask, l0.wdata} = m0_bus;
   assign {l1.request, l1.write, l1.address, l1.wmask, l1.wdata} = m1_bus;

   hwregs_arbiter #(.RESP_LATENCY(1), .M0_PRIORITY(0)) dut_rr (
      .clock(clock), .reset_n(rst_n), .m0(a0.slave), .m1(a1.slave),
      .hwregs_request(rr_req), .hwregs_write(rr_wr), .hwregs_address(rr_addr),
      .hwregs_wmask(rr_mask), .hwregs_wdata(rr_wdata), .hwregs_rvalid(hw_rvalid),
      .hwregs_rtag(hw_rtag), .hwregs_rdata(hw_rdata), .resp_error(rr_err)
   );

   hwregs_arbiter #(.RESP_LATENCY(1), .M0_PRIORITY(1)) dut_pri (
      .clock(clock), .reset_n(rst_n), .m0(p0.slave), .m1(p1.slave),
      .hwregs_request(pr_req), .hwregs_write(pr_wr), .hwregs_address(pr_addr),
      .hwregs_wmask(pr_mask), .hwregs_wdata(pr_wdata), .hwregs_rvalid(hw_rvalid),
      .hwregs_rtag(hw_rtag), .hwregs_rdata(hw_rdata), .resp_error(pr_err)
   );

   hwregs_arbiter #(.RESP_LATENCY(3), .M0_PRIORITY(0)) dut_lat (
      .clock(clock), .reset_n(rst_n), .m0(l0.slave), .m1(l1.slave),
      .hwregs_request(lt_req), .hwregs_write(lt_wr), .hwregs_address(lt_addr),
      .hwregs_wmask(lt_mask), .hwregs_wdata(lt_wdata), .hwregs_rvalid(hw_rvalid),
      .hwregs_rtag(hw_rtag), .hwregs_rdata(hw_rdata), .resp_error(lt_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [53:0] rd(input logic [15:0] a, input logic [8:0] tag);
      return {1'b1, 1'b0, a, 4'h0, 23'h0, tag};
   endfunction

   function automatic logic [53:0] wr(input logic [15:0] a, input logic [3:0] m, input logic [31:0] d);
      return {1'b1, 1'b1, a, m, d};
   endfunction

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      m0_bus    = '0;
      m1_bus    = '0;
      hw_rvalid = 1'b0;
      hw_rtag   = '0;
      hw_rdata  = '0;
      #1;
      chk("rst_req", rr_req, 0);
      chk("rst_addr", rr_addr, 0);
      chk("rst_err", rr_err, 0);
      chk("rst_ready", {a1.ready, a0.ready}, 2'b11);
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;

      // Single m0 write.
      m0_bus = wr(16'h0004, 4'hF, 32'h0000_03FF);
      tick();
      m0_bus = '0;
      chk("t1_no_early_req", rr_req, 0);
      tick();
      chk("t1_req", rr_req, 1);
      chk("t1_write", rr_wr, 1);
      chk("t1_addr", rr_addr, 32'h0004);
      chk("t1_wdata", rr_wdata, 32'h3FF);
      chk("t1_wmask", rr_mask, 4'hF);
      chk("t1_no_rvalid", {a1.rvalid, a0.rvalid}, 2'b00);
      tick();
      chk("t1_req_drop", rr_req, 0);
      chk("t1_addr_hold", rr_addr, 32'h0004);

      // m1 read with tag, response one cycle later.
      m1_bus = rd(16'h0030, 9'h1A5);
      tick();
      m1_bus = '0;
      tick();
      chk("t2_req", rr_req, 1);
      chk("t2_write", rr_wr, 0);
      chk("t2_addr", rr_addr, 32'h0030);
      chk("t2_tag", {23'h0, rr_wdata[8:0]}, 32'h1A5);
      tick();
      hw_rvalid = 1'b1;
      hw_rtag   = 9'h1A5;
      hw_rdata  = 32'h1234_5678;
      #1;
      chk("t2_m1_rvalid", a1.rvalid, 1);
      chk("t2_m0_rvalid", a0.rvalid, 0);
      chk("t2_rtag", a1.rtag, 32'h1A5);
      chk("t2_rdata", a1.rdata, 32'h1234_5678);
      tick();
      hw_rvalid = 1'b0;
      chk("t2_no_err", rr_err, 0);

      // Both masters read continuously in round-robin mode.
      m0_bus = rd(16'h0100, 9'h0A0);
      m1_bus = rd(16'h0200, 9'h0B1);
      tick();
      chk("t3_ready_c1", {a1.ready, a0.ready}, 2'b01);
      for (int k = 2; k <= 8; k++) begin
         tick();
         if (k <= 7)
            chk("t3_grant_addr", rr_addr, (k % 2 == 0) ? 32'h0100 : 32'h0200);
         else
            chk("t3_drained", rr_req, 0);
         if (k <= 5)
            chk("t3_ready", {a1.ready, a0.ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
         hw_rvalid = (k >= 3);
         hw_rtag   = 9'(k);
         if (k == 5) begin
            m0_bus = '0;
            m1_bus = '0;
         end
         #1;
         if (k >= 3)
            chk("t3_route", {a1.rvalid, a0.rvalid}, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
      hw_rvalid = 1'b0;
      tick();
      chk("t3_no_err", rr_err, 0);
      repeat (3) tick();

      // m0 priority: m1 waits while m0 keeps refilling.
      m0_bus = wr(16'h0010, 4'h3, 32'hCAFE_0000);
      m1_bus = rd(16'h0020, 9'h055);
      tick();
      m1_bus = '0;
      chk("t4_ready_c1", {p1.ready, p0.ready}, 2'b01);
      tick();
      chk("t4_m0_c2", pr_addr, 32'h0010);
      chk("t4_m1_blocked", p1.ready, 0);
      tick();
      chk("t4_m0_c3", pr_addr, 32'h0010);
      tick();
      chk("t4_m0_c4", pr_addr, 32'h0010);
      m0_bus = '0;
      tick();
      chk("t4_m0_last", pr_addr, 32'h0010);
      chk("t4_m0_last_wr", pr_wr, 1);
      tick();
      chk("t4_m1_addr", pr_addr, 32'h0020);
      chk("t4_m1_read", pr_wr, 0);
      chk("t4_m1_tag", {23'h0, pr_wdata[8:0]}, 32'h055);
      tick();
      chk("t4_idle", pr_req, 0);

      // Response with no read outstanding.
      repeat (2) tick();
      chk("t5_pre_err", rr_err, 0);
      hw_rvalid = 1'b1;
      hw_rtag   = 9'h1FF;
      #1;
      chk("t5_dropped", {a1.rvalid, a0.rvalid}, 2'b00);
      tick();
      hw_rvalid = 1'b0;
      chk("t5_err_set", rr_err, 1);
      repeat (2) tick();
      chk("t5_err_sticky", rr_err, 1);

      // Reset in the middle of a write burst.
      m0_bus = wr(16'h0040, 4'hF, 32'h0000_0001);
      tick();
      tick();
      chk("t6_busy", rr_req, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_req", rr_req, 0);
      chk("t6_async_addr", rr_addr, 0);
      chk("t6_async_err", rr_err, 0);
      repeat (2) @(posedge clock);
      #1;
      m0_bus = '0;
      rst_n  = 1'b1;
      tick();
      chk("t6_ready_after", {a1.ready, a0.ready}, 2'b11);
      chk("t6_idle_after", rr_req, 0);

      // Three-cycle latency: m0, m1, m0 reads back to back.
      m0_bus = rd(16'h0300, 9'h011);
      m1_bus = rd(16'h0310, 9'h022);
      tick();
      m1_bus = '0;
      m0_bus = rd(16'h0320, 9'h033);
      chk("t7_ready_c1", l0.ready, 1);
      tick();
      chk("t7_first", lt_addr, 32'h0300);
      m0_bus = '0;
      tick();
      chk("t7_second", lt_addr, 32'h0310);
      tick();
      chk("t7_third", lt_addr, 32'h0320);
      chk("t7_third_rd", lt_wr, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         hw_rvalid = 1'b1;
         hw_rtag   = (k == 0) ? 9'h011 : (k == 1) ? 9'h022 : 9'h033;
         hw_rdata  = 32'hAAAA_0000 + 32'(k);
         #1;
         chk("t7_route", {l1.rvalid, l0.rvalid}, (k == 1) ? 2'b10 : 2'b01);
         chk("t7_rtag", (k == 1) ? l1.rtag : l0.rtag, (k == 0) ? 9'h011 : (k == 1) ? 9'h022 : 9'h033);
      end
      tick();
      hw_rvalid = 1'b0;
      chk("t7_no_err", lt_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
